csr_access_ctrl: RTL and testbench

//  Sequences CSR instructions (CSRRW/RS/RC and immediate forms) into read/modify/write strobes for the
//  CSR register file, whose read data returns registered one cycle after rd_en. Sits between decode/execute
//  and the CSR file; stalls the pipe while busy; returns old CSR value for rd writeback; flags illegal accesses.

---
 rtl/csr_access_ctrl.sv | 104 ++++++++++
 tb/tb_csr_access_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// CSR instruction sequencer: turns CSRRW/RS/RC (and immediate forms) into read/modify/write
// strobes for a CSR file with one-cycle registered read data, and returns the old value for rd.
module csr_access_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      zimm_i,
  input  logic            rd_nz_i,
  input  logic            flush_i,
  output logic            csr_rd_en_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_idx_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            illegal_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      kind_q;
  logic [11:0]     idx_q;
  logic [XLEN-1:0] opnd_q, old_q;
  logic            need_rd_q, need_wr_q, illegal_q;

  logic            accept, need_rd, need_wr, illegal;
  logic [XLEN-1:0] opnd, old_now, wdata;

  assign op_ready_o = (state_q == S_IDLE) & rst_ni;
  assign accept     = op_valid_i & op_ready_o & ~flush_i;

  // Set/clear with a zero source operand is a pure read; writes to 0xC00-0xFFF are read-only faults.
  assign need_rd = rd_nz_i | (funct3_i[1:0] != 2'b01);
  assign need_wr = (funct3_i[1:0] == 2'b01) | (zimm_i != 5'd0);
  assign illegal = (funct3_i[1:0] == 2'b00) | (need_wr & (csr_idx_i[11:10] == 2'b11));
  assign opnd    = funct3_i[2] ? {{(XLEN-5){1'b0}}, zimm_i} : rs1_data_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = illegal ? S_RESP : (need_rd ? S_RD : S_WR);
      S_RD:   state_d = flush_i ? S_IDLE : S_WR;
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign old_now = need_rd_q ? csr_rdata_i : '0;

  always_comb begin
    case (kind_q)
      2'b10:   wdata = old_now | opnd_q;
      2'b11:   wdata = old_now & ~opnd_q;
      default: wdata = opnd_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      kind_q    <= 2'b00;
      idx_q     <= '0;
      opnd_q    <= '0;
      old_q     <= '0;
      need_rd_q <= 1'b0;
      need_wr_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q    <= funct3_i[1:0];
        idx_q     <= csr_idx_i;
        opnd_q    <= opnd;
        old_q     <= '0;
        need_rd_q <= need_rd;
        need_wr_q <= need_wr;
        illegal_q <= illegal;
      end else if (state_q == S_WR) begin
        old_q <= old_now;
      end
    end
  end

  assign csr_rd_en_o  = (state_q == S_RD);
  assign csr_wr_en_o  = (state_q == S_WR) & need_wr_q;
  assign csr_idx_o    = (csr_rd_en_o | csr_wr_en_o) ? idx_q : '0;
  assign csr_wdata_o  = csr_wr_en_o ? wdata : '0;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_valid_o ? old_q : '0;
  assign illegal_o    = resp_valid_o & illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a CSR file model feeds the DUT while a reference
// model predicts the per-cycle strobe/response timeline of every instruction.
module tb_csr_access_ctrl;
  localparam int XLEN = 32;
  localparam int PH_RD = 1, PH_WR = 2, PH_RESP = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            op_valid_i, op_ready_o;
  logic [2:0]      funct3_i;
  logic [11:0]     csr_idx_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [4:0]      zimm_i;
  logic            rd_nz_i, flush_i;
  logic            csr_rd_en_o, csr_wr_en_o;
  logic [11:0]     csr_idx_o;
  logic [XLEN-1:0] csr_wdata_o, csr_rdata_i;
  logic            resp_valid_o, illegal_o;
  logic [XLEN-1:0] resp_data_o;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] env_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        preset_en;
  logic [11:0] preset_idx;
  logic [31:0] preset_val;
  logic [11:0] idx_list [0:5];

  csr_access_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .funct3_i(funct3_i), .csr_idx_i(csr_idx_i), .rs1_data_i(rs1_data_i),
    .zimm_i(zimm_i), .rd_nz_i(rd_nz_i), .flush_i(flush_i),
    .csr_rd_en_o(csr_rd_en_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_idx_o(csr_idx_o), .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // CSR file: registered read data (random when not reading), writes on wr_en.
  always @(posedge clk_i) begin
    csr_rdata_i <= csr_rd_en_o ? env_mem[csr_idx_o] : $urandom;
    if (csr_wr_en_o) env_mem[csr_idx_o] <= csr_wdata_o;
    if (preset_en) env_mem[preset_idx] <= preset_val;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic presetCsr(input logic [11:0] idx, input logic [31:0] val);
    @(negedge clk_i);
    preset_en = 1'b1; preset_idx = idx; preset_val = val;
    ref_mem[idx] = val;
    @(negedge clk_i);
    preset_en = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_rd"}, {31'd0, csr_rd_en_o}, 0);
    checkOutput({tag, "_wr"}, {31'd0, csr_wr_en_o}, 0);
    checkOutput({tag, "_resp"}, {31'd0, resp_valid_o}, 0);
  endtask

  // Issue one CSR instruction and check every cycle until the block is idle again.
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] idx, input logic [31:0] rs1,
                               input logic [4:0] zimm, input logic rdnz, input int flush_at);
    bit need_rd, need_wr, ill, stop;
    logic [31:0] opnd, old_val, new_val;
    int phases[$];
    int ph;
    need_rd = rdnz || (f3[1:0] != 2'b01);
    need_wr = (f3[1:0] == 2'b01) || (zimm != 5'd0);
    ill     = (f3[1:0] == 2'b00) || (need_wr && idx[11:10] == 2'b11);
    opnd    = f3[2] ? {27'd0, zimm} : rs1;
    old_val = (need_rd && !ill) ? ref_mem[idx] : 32'd0;
    case (f3[1:0])
      2'b01:   new_val = opnd;
      2'b10:   new_val = old_val | opnd;
      default: new_val = old_val & ~opnd;
    endcase
    phases.delete();
    if (!ill && need_rd) phases.push_back(PH_RD);
    if (!ill) phases.push_back(PH_WR);
    phases.push_back(PH_RESP);

    @(negedge clk_i);
    op_valid_i = 1'b1; funct3_i = f3; csr_idx_i = idx; rs1_data_i = rs1;
    zimm_i = zimm; rd_nz_i = rdnz; flush_i = 1'b0;
    checkOutput("ready_before", {31'd0, op_ready_o}, 1);
    @(negedge clk_i);
    op_valid_i = 1'b0; funct3_i = 3'($urandom); csr_idx_i = 12'($urandom);
    rs1_data_i = $urandom; zimm_i = 5'($urandom); rd_nz_i = 1'($urandom);
    stop = 0;
    for (int k = 0; k < phases.size() && !stop; k++) begin
      ph = phases[k];
      flush_i = (k == flush_at);
      checkOutput("busy_ready", {31'd0, op_ready_o}, 0);
      checkOutput("rd_en", {31'd0, csr_rd_en_o}, (ph == PH_RD) ? 1 : 0);
      checkOutput("wr_en", {31'd0, csr_wr_en_o}, (ph == PH_WR && need_wr) ? 1 : 0);
      checkOutput("csr_idx", {20'd0, csr_idx_o},
                  (ph == PH_RD || (ph == PH_WR && need_wr)) ? {20'd0, idx} : 32'd0);
      checkOutput("wdata", csr_wdata_o, (ph == PH_WR && need_wr) ? new_val : 32'd0);
      checkOutput("resp_valid", {31'd0, resp_valid_o}, (ph == PH_RESP) ? 1 : 0);
      checkOutput("illegal", {31'd0, illegal_o}, (ph == PH_RESP && ill) ? 1 : 0);
      if (ph == PH_RESP) checkOutput("resp_data", resp_data_o, old_val);
      if (flush_i && ph == PH_RD) stop = 1;
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    checkOutput("ready_after", {31'd0, op_ready_o}, 1);
    checkQuiet("idle_after");
    if (!ill && !stop && need_wr) ref_mem[idx] = new_val;
  endtask

  initial begin
    idx_list[0] = 12'h300; idx_list[1] = 12'h305; idx_list[2] = 12'h340;
    idx_list[3] = 12'h341; idx_list[4] = 12'hF11; idx_list[5] = 12'hC00;
    rst_ni = 1'b0; op_valid_i = 1'b0; funct3_i = 3'd0; csr_idx_i = 12'd0;
    rs1_data_i = 32'd0; zimm_i = 5'd0; rd_nz_i = 1'b0; flush_i = 1'b0;
    preset_en = 1'b0; preset_idx = 12'd0; preset_val = 32'd0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_ready", {31'd0, op_ready_o}, 0);
    checkQuiet("rst");
    checkOutput("rst_idx", {20'd0, csr_idx_o}, 0);
    checkOutput("rst_wdata", csr_wdata_o, 0);
    checkOutput("rst_rdata", resp_data_o, 0);
    checkOutput("rst_illegal", {31'd0, illegal_o}, 0);
    for (int i = 0; i < 6; i++) presetCsr(idx_list[i], $urandom);
    presetCsr(12'h7C0, 32'h1234_5678);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases from the block description
    presetCsr(12'h300, 32'h8);
    applyStimulus(3'b001, 12'h300, 32'hDEAD_BEEF, 5'd1, 1'b1, -1);
    presetCsr(12'h300, 32'h8);
    applyStimulus(3'b010, 12'h300, 32'h3, 5'd3, 1'b1, -1);
    applyStimulus(3'b011, 12'h300, 32'h8, 5'd4, 1'b1, -1);
    applyStimulus(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b1, -1);
    applyStimulus(3'b001, 12'h305, 32'hCAFE_0001, 5'd2, 1'b0, -1);
    applyStimulus(3'b001, 12'hF11, 32'h1, 5'd1, 1'b1, -1);
    applyStimulus(3'b100, 12'h300, 32'h1, 5'd1, 1'b1, -1);
    applyStimulus(3'b010, 12'hF11, 32'h0, 5'd0, 1'b1, -1);
    applyStimulus(3'b001, 12'h340, 32'h5555_AAAA, 5'd7, 1'b1, 0);
    applyStimulus(3'b001, 12'h340, 32'hA5A5_5A5A, 5'd7, 1'b1, 1);
    applyStimulus(3'b101, 12'h341, 32'h0, 5'd9, 1'b0, 0);

    // Flush in IDLE blocks acceptance
    @(negedge clk_i);
    op_valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b001; csr_idx_i = 12'h300;
    rd_nz_i = 1'b1; zimm_i = 5'd1;
    @(negedge clk_i);
    op_valid_i = 1'b0; flush_i = 1'b0;
    checkOutput("idle_flush_ready", {31'd0, op_ready_o}, 1);
    checkQuiet("idle_flush");
    @(negedge clk_i);
    checkQuiet("idle_flush2");

    // Reset during WR
    @(negedge clk_i);
    op_valid_i = 1'b1; funct3_i = 3'b001; csr_idx_i = 12'h7C0;
    rs1_data_i = 32'h0BAD_F00D; zimm_i = 5'd3; rd_nz_i = 1'b1;
    @(negedge clk_i);
    op_valid_i = 1'b0;
    checkOutput("rstop_rd", {31'd0, csr_rd_en_o}, 1);
    @(negedge clk_i);
    checkOutput("rstop_wr", {31'd0, csr_wr_en_o}, 1);
    rst_ni = 1'b0;
    #1 checkOutput("rstop_ready_low", {31'd0, op_ready_o}, 0);
    @(negedge clk_i);
    checkQuiet("rstop_after");
    checkOutput("rstop_ready", {31'd0, op_ready_o}, 0);
    @(negedge clk_i);
    checkOutput("rstop_idle_ready", {31'd0, op_ready_o}, 0);
    checkQuiet("rstop_idle");
    rst_ni = 1'b1;
    #1 checkOutput("rstop_release", {31'd0, op_ready_o}, 1);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  rf3;
      logic [4:0]  rz;
      int          fa;
      rf3 = 3'($urandom);
      rz  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      applyStimulus(rf3, idx_list[$urandom_range(0, 5)], $urandom, rz, 1'($urandom), fa);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
